// File: rtl/ipu_isa_pkg.sv
// Shared ISA constants and sequencing types for the image-processing unit.
// Provides the 4-bit opcode map, the instruction issuer state encoding and
// small helpers used to classify opcodes and size counters.
package ipu_isa_pkg;

  localparam logic [3:0] READ         = 4'b0001;
  localparam logic [3:0] WRITE        = 4'b0010;
  localparam logic [3:0] CONV         = 4'b0011;
  localparam logic [3:0] CONV_TRSP    = 4'b0100;
  localparam logic [3:0] CONV_ROB     = 4'b0101;
  localparam logic [3:0] B2G          = 4'b0110;
  localparam logic [3:0] CONVERT_GREY = 4'b1100;
  localparam logic [3:0] PHOTO_CONV   = 4'b1110;
  localparam logic [3:0] READ_IMAGE   = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RD_LAT,
    HOLD,
    CAPTURE,
    RESPOND
  } issuer_state_t;

  // Level-triggered opcodes are held on the bus instead of being pulsed.
  function automatic logic is_level_op(input logic [3:0] op);
    return (op == PHOTO_CONV) || (op == CONVERT_GREY);
  endfunction

  // Opcodes that complete without an activate pulse.
  function automatic logic is_silent_op(input logic [3:0] op);
    return is_level_op(op) || (op == READ_IMAGE);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/issue_timer.sv
// Loadable down-counter shared by all timed states of the issuer.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (count -> 0)
//   load        - load load_value (has priority over enable)
//   load_value  - count to load
//   enable      - decrement by one, saturating at zero
//   terminal    - high while the count is 1, i.e. the last counted cycle
module issue_timer #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/instruction_issuer.sv
// Accepts one instruction word at a time, issues it to the coprocessor,
// tracks completion (ack/busy handshake, fixed read latency or fixed hold
// time) and returns a single response word, flagging timeouts.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data - command handshake; opcode in cmd_data[3:0]
//   instruction               - word driven to the coprocessor (0 when idle)
//   activate_signal           - bit0 one-cycle activate pulse, bit1 always 0
//   wait_signal               - coprocessor busy
//   data_read                 - coprocessor / image memory read data
//   rsp_valid/rsp_ready/rsp_data/rsp_err - response handshake, err = timeout
//   busy                      - high whenever not idle
module instruction_issuer
  import ipu_isa_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned HOLD_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  output logic [31:0] instruction,
  output logic [1:0]  activate_signal,
  input  logic        wait_signal,
  input  logic [31:0] data_read,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy
);

  localparam int unsigned ACK_WINDOW = 2;
  localparam int unsigned CNT_MAX =
    max3(max3(TIMEOUT_CYCLES, READ_LATENCY, HOLD_CYCLES), ACK_WINDOW, 1);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  issuer_state_t state;
  logic [31:0]   instr_reg;
  logic [3:0]    opcode;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_enable;
  logic             tmr_terminal;

  // instr_reg is cleared on return to IDLE, so it doubles as the bus value.
  assign instruction = instr_reg;
  assign opcode      = instr_reg[3:0];

  issue_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .enable     (tmr_enable),
    .terminal   (tmr_terminal)
  );

  // Each timed state gets its count loaded on the cycle before it is entered.
  always_comb begin
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_enable = 1'b0;
    case (state)
      ISSUE: begin
        tmr_load = 1'b1;
        if (opcode == READ_IMAGE)  tmr_value = CNT_W'(READ_LATENCY);
        else if (is_level_op(opcode)) tmr_value = CNT_W'(HOLD_CYCLES);
        else                       tmr_value = CNT_W'(ACK_WINDOW);
      end
      WAIT_ACK: begin
        if (wait_signal) begin
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(TIMEOUT_CYCLES);
        end else begin
          tmr_enable = 1'b1;
        end
      end
      WAIT_DONE: tmr_enable = wait_signal;
      RD_LAT:    tmr_enable = 1'b1;
      HOLD:      tmr_enable = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      instr_reg       <= '0;
      cmd_ready       <= 1'b1;
      activate_signal <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      activate_signal <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            instr_reg <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ISSUE;
            // Registered pulse: asserted for the single ISSUE cycle.
            if (!is_silent_op(cmd_data[3:0])) activate_signal <= 2'b01;
          end
        end
        ISSUE: begin
          if (opcode == READ_IMAGE)      state <= RD_LAT;
          else if (is_level_op(opcode))  state <= HOLD;
          else                           state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (wait_signal)       state <= WAIT_DONE;
          else if (tmr_terminal) state <= CAPTURE;
        end
        WAIT_DONE: begin
          if (!wait_signal) begin
            state <= CAPTURE;
          end else if (tmr_terminal) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end
        end
        RD_LAT: begin
          if (tmr_terminal) state <= CAPTURE;
        end
        HOLD: begin
          if (tmr_terminal) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end
        end
        CAPTURE: begin
          rsp_data  <= (opcode == READ) ? {16'h0, data_read[15:0]} : data_read;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            instr_reg <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_issuer.sv
// Self-checking bench for instruction_issuer: reset checks, a table of
// directed transactions, hand-written reset sequences and randomized
// transactions checked against a cycle-count model of the protocol.
module tb_instruction_issuer;

  localparam int unsigned T  = 16;
  localparam int unsigned RL = 2;
  localparam int unsigned HC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic [31:0] instruction;
  logic [1:0]  activate_signal;
  logic        wait_signal;
  logic [31:0] data_read;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  instruction_issuer #(
    .TIMEOUT_CYCLES (T),
    .READ_LATENCY   (RL),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_data        (cmd_data),
    .cmd_ready       (cmd_ready),
    .instruction     (instruction),
    .activate_signal (activate_signal),
    .wait_signal     (wait_signal),
    .data_read       (data_read),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .rsp_ready       (rsp_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " instruction"}, instruction, 32'h0);
    chk({tag, " activate"}, 32'(activate_signal), 32'd0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " rsp_data"}, rsp_data, 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Model: handshake cycle is 0, ISSUE (and any activate pulse) is cycle 1.
  // wait_signal is low for d cycles after the pulse then high for n cycles.
  // data_read in cycle k is base+k; capture happens the cycle before RESPOND.
  task automatic model(input logic [31:0] cmd, input int d, input int n,
                       input logic [31:0] base, output int lat,
                       output logic [31:0] data, output logic err, output int act);
    logic [3:0] op;
    int a;
    bit zero_rsp;
    op = cmd[3:0];
    err = 1'b0;
    zero_rsp = 1'b0;
    if (op == 4'hF) begin
      act = 0;
      lat = 1 + RL + 2;
    end else if (op == 4'hE || op == 4'hC) begin
      act = 0;
      lat = 1 + HC + 1;
      zero_rsp = 1'b1;
    end else begin
      act = 1;
      if (d >= 2 || n == 0) begin
        lat = 1 + 2 + 2;
      end else begin
        a = 2 + d;
        if (n - 1 >= int'(T)) begin
          lat = a + int'(T) + 1;
          err = 1'b1;
          zero_rsp = 1'b1;
        end else begin
          lat = a + n + 2;
        end
      end
    end
    if (zero_rsp) data = 32'h0;
    else begin
      data = base + 32'(lat - 1);
      if (op == 4'h1) data = {16'h0, data[15:0]};
    end
  endtask

  // Called at #1 after a clock edge with the DUT idle.
  task automatic run_txn(input string tag, input logic [31:0] cmd, input int d,
                         input int n, input logic [31:0] base, input int rdy_delay,
                         input int exp_lat, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_act);
    int act_cnt, act_k, rsp_k, bad_hold, unstable;
    logic [31:0] got_data;
    logic got_err;
    bit done, hs, level;
    level = (cmd[3:0] == 4'hF) || (cmd[3:0] == 4'hE) || (cmd[3:0] == 4'hC);
    act_cnt = 0; act_k = -1; rsp_k = -1; bad_hold = 0; unstable = 0;
    done = 1'b0; hs = 1'b0; got_data = '0; got_err = 1'b0;
    chk({tag, " ready before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_data = cmd; wait_signal = 1'b0;
    data_read = base; rsp_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 200 && !done; k++) begin
      if (hs) begin
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle instruction"}, instruction, 32'h0);
        chk({tag, " idle ready"}, 32'(cmd_ready & ~busy), 32'd1);
        done = 1'b1;
      end else begin
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || instruction !== cmd) bad_hold++;
        if (activate_signal[1] !== 1'b0) bad_hold++;
        if (activate_signal[0] === 1'b1) begin
          act_cnt++;
          if (act_k < 0) act_k = k;
        end
        if (rsp_valid === 1'b1) begin
          if (rsp_k < 0) begin
            rsp_k = k; got_data = rsp_data; got_err = rsp_err;
          end else if (rsp_data !== got_data || rsp_err !== got_err) begin
            unstable++;
          end
        end
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data = $urandom;
        data_read = base + 32'(k);
        if (level) wait_signal = 1'($urandom_range(0, 1));
        else wait_signal = (n > 0) && (d < 2) && (k >= 2 + d) && (k < 2 + d + n);
        rsp_ready = (rsp_k >= 0) && (k - rsp_k >= rdy_delay);
        hs = rsp_valid && rsp_ready;
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; wait_signal = 1'b0;
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(rsp_k), 32'(exp_lat));
    chk({tag, " rsp_data"}, got_data, exp_data);
    chk({tag, " rsp_err"}, 32'(got_err), 32'(exp_err));
    chk({tag, " activates"}, 32'(act_cnt), 32'(exp_act));
    if (exp_act != 0) chk({tag, " activate cycle"}, 32'(act_k), 32'd1);
    chk({tag, " busy hold"}, 32'(bad_hold), 32'd0);
    chk({tag, " rsp stable"}, 32'(unstable), 32'd0);
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          d;
    int          n;
    logic [31:0] base;
    int          rdy;
    int          lat;
    logic [31:0] data;
    logic        err;
    int          act;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, act;
    logic [31:0] data, cmd;
    logic err;
    int d, n;
    logic [3:0] ops[12];

    vecs[0] = '{32'h0000_0012, 0, 5,  32'h5000_0000, 0, 9,  32'h5000_0008, 1'b0, 1};
    vecs[1] = '{32'h0000_0001, 2, 0,  32'hABCD_1230, 1, 5,  32'h0000_1234, 1'b0, 1};
    vecs[2] = '{32'h0001_000F, 0, 0,  32'h1111_0000, 0, 5,  32'h1111_0004, 1'b0, 0};
    vecs[3] = '{32'h0000_00AE, 0, 0,  32'h2222_0000, 2, 6,  32'h0000_0000, 1'b0, 0};
    vecs[4] = '{32'h0000_003C, 0, 0,  32'h3333_0000, 0, 6,  32'h0000_0000, 1'b0, 0};
    vecs[5] = '{32'h0000_0103, 0, 40, 32'h4444_0000, 0, 19, 32'h0000_0000, 1'b1, 1};
    vecs[6] = '{32'h0000_0004, 1, 3,  32'h7000_0000, 0, 8,  32'h7000_0007, 1'b0, 1};
    vecs[7] = '{32'h0000_0005, 0, 16, 32'h8000_0000, 0, 20, 32'h8000_0013, 1'b0, 1};
    vecs[8] = '{32'h0000_0006, 0, 17, 32'h8800_0000, 1, 19, 32'h0000_0000, 1'b1, 1};
    vecs[9] = '{32'h0000_0002, 0, 1,  32'h9000_0000, 3, 5,  32'h9000_0004, 1'b0, 1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; wait_signal = 1'b0;
    data_read = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].d, vecs[i].n, vecs[i].base,
              vecs[i].rdy, vecs[i].lat, vecs[i].data, vecs[i].err, vecs[i].act);
    end

    // Reset while the coprocessor is busy: the command is dropped silently.
    cmd_valid = 1'b1; cmd_data = 32'h0000_0012; data_read = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      wait_signal = (k >= 2);
      @(posedge clk); #1;
    end
    chk("mid-op busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outputs("mid-op reset");
    begin
      int seen;
      seen = 0;
      wait_signal = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("no rsp after reset", 32'(seen), 32'd0);
    end

    // Command presented together with reset must not be taken.
    reset = 1'b1; cmd_valid = 1'b1; cmd_data = 32'h0000_0012;
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("reset+cmd busy", 32'(busy), 32'd0);
    chk("reset+cmd instruction", instruction, 32'h0);

    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hE, 4'hF};
    for (int i = 0; i < 40; i++) begin
      cmd = {$urandom, 4'h0} | 32'(ops[$urandom_range(0, 11)]);
      d = $urandom_range(0, 2);
      n = (d == 2) ? 0 : int'($urandom_range(0, 20));
      data = $urandom;
      model(cmd, d, n, data, lat, cmd, err, act);
      // model reuses cmd as the data output; rebuild the command word
      run_rand(i, d, n, data, lat, err, act);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic run_rand(input int i, input int d, input int n, input logic [31:0] base,
                          input int lat_unused, input logic err_unused, input int act_unused);
    logic [31:0] cmd, exp_data;
    int lat, act;
    logic err;
    cmd = {$urandom} & 32'hFFFF_FFF0;
    case ($urandom_range(0, 11))
      0: cmd[3:0] = 4'h0;   1: cmd[3:0] = 4'h1;   2: cmd[3:0] = 4'h2;
      3: cmd[3:0] = 4'h3;   4: cmd[3:0] = 4'h4;   5: cmd[3:0] = 4'h5;
      6: cmd[3:0] = 4'h6;   7: cmd[3:0] = 4'h7;   8: cmd[3:0] = 4'h9;
      9: cmd[3:0] = 4'hC;   10: cmd[3:0] = 4'hE;  default: cmd[3:0] = 4'hF;
    endcase
    model(cmd, d, n, base, lat, exp_data, err, act);
    run_txn($sformatf("rand%0d", i), cmd, d, n, base, int'($urandom_range(0, 3)),
            lat, exp_data, err, act);
    if (lat_unused < 0 && err_unused && act_unused < 0) $display("unreachable");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
